// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared op encoding, access sizes and mem-op classification for mem_access
package mem_access_pkg;

    typedef enum logic [4:0] {
        OP_NOP, OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LUI,
        OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD
    } instruction_type;

    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

    typedef logic [7:0] strobe_t;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} mem_state_t;

    function automatic logic is_load(instruction_type op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(instruction_type op);
        case (op)
            OP_SB, OP_SH, OP_SW, OP_SD: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(instruction_type op);
        return is_load(op) | is_store(op);
    endfunction

    function automatic msize_t op_size(instruction_type op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return MSIZE1;
            OP_LH, OP_LHU, OP_SH: return MSIZE2;
            OP_LW, OP_LWU, OP_SW: return MSIZE4;
            default:              return MSIZE8;
        endcase
    endfunction

    // Lanes shifted past byte 7 are dropped: a misaligned access is truncated, not split.
    function automatic strobe_t store_strobe(msize_t size, logic [2:0] off);
        case (size)
            MSIZE1:  return 8'h01 << off;
            MSIZE2:  return 8'h03 << off;
            MSIZE4:  return 8'h0F << off;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic is_misaligned(msize_t size, logic [2:0] off);
        case (size)
            MSIZE1:  return 1'b0;
            MSIZE2:  return off[0];
            MSIZE4:  return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/load_extender.sv
// rtl/load_extender.sv - selects the addressed lane of a read word and sign/zero-extends it
module load_extender
    import mem_access_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  instruction_type   op,
    input  logic [2:0]        offset,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   result
);

    logic [XLEN-1:0] lane;

    assign lane = rdata >> {offset, 3'b000};

    always_comb begin
        result = lane;
        case (op)
            OP_LB:   result = {{(XLEN-8){lane[7]}},   lane[7:0]};
            OP_LH:   result = {{(XLEN-16){lane[15]}}, lane[15:0]};
            OP_LW:   result = {{(XLEN-32){lane[31]}}, lane[31:0]};
            OP_LBU:  result = {{(XLEN-8){1'b0}},      lane[7:0]};
            OP_LHU:  result = {{(XLEN-16){1'b0}},     lane[15:0]};
            OP_LWU:  result = {{(XLEN-32){1'b0}},     lane[31:0]};
            default: result = lane;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory stage: data bus request, load alignment, writeback handshake
// Optional MISALIGN_TRAP_EN: misaligned mem ops fault without a bus request and expose the misalign port.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  instruction_type      in_op,
    input  logic [XLEN-1:0]      in_result,
    input  logic [XLEN-1:0]      in_wdata,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_wb_en,
    output logic                 dreq_valid,
    output logic [XLEN-1:0]      dreq_addr,
    output msize_t               dreq_size,
    output strobe_t              dreq_strobe,
    output logic [XLEN-1:0]      dreq_data,
    input  logic                 dresp_ok,
    input  logic [XLEN-1:0]      dresp_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_data,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic                 out_wb_en
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                 misalign
`endif
);

    mem_state_t      state_q, state_d;
    instruction_type op_q;
    logic            accept;
    logic            in_mem;
    logic            in_misal;
    logic [2:0]      in_off;
    msize_t          in_size;
    logic [XLEN-1:0] load_word;

    assign in_off  = in_result[2:0];
    assign in_size = op_size(in_op);
    assign in_mem  = is_mem(in_op);
    assign accept  = in_valid & in_ready;

`ifdef MISALIGN_TRAP_EN
    logic misal_q;

    assign in_misal = in_mem & is_misaligned(in_size, in_off);
    assign misalign = misal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misal_q <= 1'b0;
        end else if (accept) begin
            misal_q <= in_misal;
        end
    end
`else
    assign in_misal = 1'b0;
`endif

    assign in_ready   = (state_q == ST_IDLE);
    assign dreq_valid = (state_q == ST_REQ);
    assign out_valid  = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = (in_mem && !in_misal) ? ST_REQ : ST_DONE;
            ST_REQ:  if (dresp_ok)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // The captured address offset also drives load lane selection while in REQ.
    load_extender #(.XLEN(XLEN)) u_load_extender (
        .op     (op_q),
        .offset (dreq_addr[2:0]),
        .rdata  (dresp_data),
        .result (load_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= OP_NOP;
            dreq_addr   <= '0;
            dreq_size   <= MSIZE1;
            dreq_strobe <= '0;
            dreq_data   <= '0;
            out_data    <= '0;
            out_rd      <= '0;
            out_wb_en   <= 1'b0;
        end else if (accept) begin
            op_q      <= in_op;
            out_data  <= in_result;
            out_rd    <= in_rd;
            out_wb_en <= in_wb_en & ~is_store(in_op) & ~in_misal;
            if (in_mem && !in_misal) begin
                dreq_addr   <= in_result;
                dreq_size   <= in_size;
                dreq_strobe <= is_store(in_op) ? store_strobe(in_size, in_off) : '0;
                dreq_data   <= is_store(in_op) ? (in_wdata << {in_off, 3'b000}) : '0;
            end
        end else if (state_q == ST_REQ && dresp_ok && is_load(op_q)) begin
            out_data <= load_word;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard bench for mem_access with directed load/store/pass-through vectors
module tb_mem_access;
    import mem_access_pkg::*;

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    instruction_type in_op;
    logic [63:0]     in_result;
    logic [63:0]     in_wdata;
    logic [4:0]      in_rd;
    logic            in_wb_en;
    logic            dreq_valid;
    logic [63:0]     dreq_addr;
    msize_t          dreq_size;
    strobe_t         dreq_strobe;
    logic [63:0]     dreq_data;
    logic            dresp_ok;
    logic [63:0]     dresp_data;
    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_data;
    logic [4:0]      out_rd;
    logic            out_wb_en;
`ifdef MISALIGN_TRAP_EN
    logic            misalign;
`endif

    mem_access #(.XLEN(64), .REG_IDX_W(5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_result   (in_result),
        .in_wdata    (in_wdata),
        .in_rd       (in_rd),
        .in_wb_en    (in_wb_en),
        .dreq_valid  (dreq_valid),
        .dreq_addr   (dreq_addr),
        .dreq_size   (dreq_size),
        .dreq_strobe (dreq_strobe),
        .dreq_data   (dreq_data),
        .dresp_ok    (dresp_ok),
        .dresp_data  (dresp_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_rd      (out_rd),
        .out_wb_en   (out_wb_en)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign    (misalign)
`endif
    );

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        wb_en;
        logic        mis;
        logic        chk_data;
    } out_exp_t;

    typedef struct {
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic        store;
        int          cycles;
    } req_exp_t;

    out_exp_t out_q[$];
    req_exp_t req_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int dreq_cycles = 0;
    int resp_delay = 0;
    int resp_cnt = 0;
    logic [63:0] resp_data = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus model: completes after resp_delay cycles of dreq_valid (0 = same cycle).
    always @(posedge clk) begin
        #1;
        if (reset_n && dreq_valid) begin
            dresp_ok = (resp_cnt >= resp_delay);
            resp_cnt++;
        end else begin
            dresp_ok = 1'b0;
            resp_cnt = 0;
        end
        dresp_data = resp_data;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (dreq_valid) begin
                dreq_cycles++;
                if (req_q.size() == 0) begin
                    check("unexpected_dreq", 64'd1, 64'd0);
                end else begin
                    check("dreq_addr", dreq_addr, req_q[0].addr);
                    check("dreq_size", 64'(dreq_size), 64'(req_q[0].size));
                    check("dreq_strobe", 64'(dreq_strobe), 64'(req_q[0].strobe));
                    if (req_q[0].store) check("dreq_data", dreq_data, req_q[0].data);
                    if (dresp_ok) begin
                        check("dreq_hold_cycles", 64'(dreq_cycles), 64'(req_q[0].cycles));
                        void'(req_q.pop_front());
                        dreq_cycles = 0;
                    end
                end
            end
            if (out_valid) begin
                check("in_ready_low_in_done", 64'(in_ready), 64'd0);
                if (out_q.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    if (out_q[0].chk_data) check("out_data", out_data, out_q[0].data);
                    check("out_rd", 64'(out_rd), 64'(out_q[0].rd));
                    check("out_wb_en", 64'(out_wb_en), 64'(out_q[0].wb_en));
`ifdef MISALIGN_TRAP_EN
                    check("misalign", 64'(misalign), 64'(out_q[0].mis));
`endif
                    if (out_ready) void'(out_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input instruction_type op, input logic [63:0] result,
                         input logic [63:0] wdata, input logic [4:0] rd, input logic wb_en);
        in_op     = op;
        in_result = result;
        in_wdata  = wdata;
        in_rd     = rd;
        in_wb_en  = wb_en;
        in_valid  = 1'b1;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (in_ready) break;
            if (i > 50) begin
                check("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (out_q.size() == 0 && req_q.size() == 0) break;
            @(posedge clk);
        end
        check("drain_timeout", 64'(out_q.size() + req_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic mem_op(input instruction_type op, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] rdata, input msize_t size, input logic [7:0] strobe,
                          input logic [63:0] sdata, input logic [63:0] exp_out, input logic [4:0] rd,
                          input int delay, input logic store);
        resp_delay = delay;
        resp_data  = rdata;
        req_q.push_back('{addr, size, strobe, sdata, store, delay + 1});
        out_q.push_back('{exp_out, rd, ~store, 1'b0, ~store});
        issue(op, addr, wdata, rd, 1'b1);
        @(negedge clk);
        check("mem_min_latency", 64'(out_valid), 64'd0);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_op     = OP_NOP;
        in_result = '0;
        in_wdata  = '0;
        in_rd     = '0;
        in_wb_en  = 1'b0;
        out_ready = 1'b1;
        dresp_ok  = 1'b0;
        dresp_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dreq_valid", 64'(dreq_valid), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_wb_en", 64'(out_wb_en), 64'd0);
        check("rst_strobe", 64'(dreq_strobe), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_dreq_addr", dreq_addr, 64'd0);
        check("rst_dreq_data", dreq_data, 64'd0);
`ifdef MISALIGN_TRAP_EN
        check("rst_misalign", 64'(misalign), 64'd0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // pass-through, latency 1
        out_q.push_back('{64'h1234, 5'd3, 1'b1, 1'b0, 1'b1});
        issue(OP_ADDI, 64'h1234, 64'h0, 5'd3, 1'b1);
        @(negedge clk);
        check("addi_latency", 64'(out_valid), 64'd1);
        check("addi_no_dreq", 64'(dreq_valid), 64'd0);
        drain();

        //      op      addr              wdata                  rdata                  size    strb   sdata                  expected out           rd  dly st
        mem_op(OP_LB,  64'h1003,         64'h0,                 64'h0000_0000_8000_0000, MSIZE1, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80, 5'd4, 1, 1'b0);
        mem_op(OP_SH,  64'h2006,         64'hBEEF,              64'h0,                 MSIZE2, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0,                 5'd5, 2, 1'b1);
        mem_op(OP_LB,  64'h0001,         64'h0,                 64'hF1E2_D3C4_B5A6_9788, MSIZE1, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FF97, 5'd6, 0, 1'b0);
        mem_op(OP_LBU, 64'h0005,         64'h0,                 64'hF1E2_D3C4_B5A6_9788, MSIZE1, 8'h00, 64'h0,                 64'h0000_0000_0000_00D3, 5'd7, 0, 1'b0);
        mem_op(OP_LH,  64'h0002,         64'h0,                 64'hF1E2_D3C4_B5A6_9788, MSIZE2, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_B5A6, 5'd8, 1, 1'b0);
        mem_op(OP_LHU, 64'h0006,         64'h0,                 64'hF1E2_D3C4_B5A6_9788, MSIZE2, 8'h00, 64'h0,                 64'h0000_0000_0000_F1E2, 5'd9, 0, 1'b0);
        mem_op(OP_LW,  64'h0000,         64'h0,                 64'hF1E2_D3C4_B5A6_9788, MSIZE4, 8'h00, 64'h0,                 64'hFFFF_FFFF_B5A6_9788, 5'd10, 0, 1'b0);
        mem_op(OP_LD,  64'h0008,         64'h0,                 64'hF1E2_D3C4_B5A6_9788, MSIZE8, 8'h00, 64'h0,                 64'hF1E2_D3C4_B5A6_9788, 5'd11, 3, 1'b0);
        mem_op(OP_SB,  64'h3005,         64'hAB,                64'h0,                 MSIZE1, 8'h20, 64'h0000_AB00_0000_0000, 64'h0,                 5'd12, 0, 1'b1);
        mem_op(OP_SW,  64'h4004,         64'hCAFE_F00D,         64'h0,                 MSIZE4, 8'hF0, 64'hCAFE_F00D_0000_0000, 64'h0,                 5'd13, 1, 1'b1);
        mem_op(OP_SD,  64'h5000,         64'h0123_4567_89AB_CDEF, 64'h0,               MSIZE8, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0,                 5'd14, 0, 1'b1);

        // LWU, same-cycle completion, writeback stalled for 2 cycles
        resp_delay = 0;
        resp_data  = 64'hDEAD_BEEF_1234_5678;
        out_ready  = 1'b0;
        req_q.push_back('{64'h8004, MSIZE4, 8'h00, 64'h0, 1'b0, 1});
        out_q.push_back('{64'h0000_0000_DEAD_BEEF, 5'd15, 1'b1, 1'b0, 1'b1});
        issue(OP_LWU, 64'h8004, 64'h0, 5'd15, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("lwu_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("lwu_held_unpopped", 64'(out_q.size()), 64'd1);
        out_ready = 1'b1;
        drain();

        // reset while a request is outstanding
        resp_delay = 1000;
        resp_data  = 64'h0;
        req_q.push_back('{64'h6000, MSIZE8, 8'h00, 64'h0, 1'b0, 1001});
        out_q.push_back('{64'h0, 5'd16, 1'b1, 1'b0, 1'b1});
        issue(OP_LD, 64'h6000, 64'h0, 5'd16, 1'b1);
        @(negedge clk);
        check("pre_reset_dreq_valid", 64'(dreq_valid), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("reset_drops_dreq_valid", 64'(dreq_valid), 64'd0);
        check("reset_drops_out_valid", 64'(out_valid), 64'd0);
        req_q.delete();
        out_q.delete();
        dreq_cycles = 0;
        resp_delay = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        check("post_reset_dreq_valid", 64'(dreq_valid), 64'd0);
        @(posedge clk);
        #1;

        out_q.push_back('{64'hABCD, 5'd17, 1'b1, 1'b0, 1'b1});
        issue(OP_ADD, 64'hABCD, 64'h0, 5'd17, 1'b1);
        drain();

`ifdef MISALIGN_TRAP_EN
        out_q.push_back('{64'h0, 5'd18, 1'b0, 1'b1, 1'b0});
        issue(OP_LD, 64'h7004, 64'h0, 5'd18, 1'b1);
        @(negedge clk);
        check("misalign_no_dreq", 64'(dreq_valid), 64'd0);
        check("misalign_out_valid", 64'(out_valid), 64'd1);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
